// File: rtl/serial_nibble_loader.sv
// Assembles WIDTH-bit words from a framed serial bit stream. Each completed word
// is presented on d_out together with a one-cycle load strobe.
module serial_nibble_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] d_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       word_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seeded;

  // shifted: shreg with the current bit appended; seeded: a fresh word holding only
  // the current bit, placed so that WIDTH-1 further shifts move it to its final slot.
  always_comb begin
    shifted = shreg;
    seeded  = '0;
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], sin_data};
      seeded  = {{(WIDTH-1){1'b0}}, sin_data};
    end else begin
      shifted = {sin_data, shreg[WIDTH-1:1]};
      seeded  = {sin_data, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      d_out     <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sin_valid && sin_start) begin
            shreg <= seeded;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            if (sin_start) begin
              // A new start bit abandons the partial word and begins the next one.
              frame_err <= 1'b1;
              shreg     <= seeded;
              cnt       <= CW'(1);
            end else if (cnt == CW'(WIDTH - 1)) begin
              d_out    <= shifted;
              load     <= 1'b1;
              word_cnt <= word_cnt + 8'd1;
              shreg    <= shifted;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              shreg <= shifted;
              cnt   <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Drives one serial stream into an MSB-first and an LSB-first loader and checks
// both against a bit-queue reference model through per-instance expected queues.
module tb_serial_nibble_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sin_valid = 1'b0;
  logic sin_data = 1'b0;
  logic sin_start = 1'b0;

  logic [3:0] d_out_m, d_out_l;
  logic       load_m, load_l, busy_m, busy_l, fe_m, fe_l;
  logic [7:0] wc_m, wc_l;

  always #5 clk = ~clk;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_start(sin_start), .d_out(d_out_m), .load(load_m), .busy(busy_m),
    .frame_err(fe_m), .word_cnt(wc_m)
  );

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_start(sin_start), .d_out(d_out_l), .load(load_l), .busy(busy_l),
    .frame_err(fe_l), .word_cnt(wc_l)
  );

  logic [3:0] d_o [2];
  logic       ld  [2];
  logic       bz  [2];
  logic       fe  [2];
  logic [7:0] wc  [2];
  assign d_o[0] = d_out_m;  assign d_o[1] = d_out_l;
  assign ld[0]  = load_m;   assign ld[1]  = load_l;
  assign bz[0]  = busy_m;   assign bz[1]  = busy_l;
  assign fe[0]  = fe_m;     assign fe[1]  = fe_l;
  assign wc[0]  = wc_m;     assign wc[1]  = wc_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  // Reference model state: bits of the word being framed, in arrival order.
  logic [11:0] exp_q [2][$];
  int          due_q [2][$];
  int          err_due_q [2][$];
  bit          bits_q[$];
  bit          in_prog = 1'b0;
  bit          busy_exp = 1'b0;
  logic [7:0]  cnt_exp = 8'd0;
  logic [3:0]  last_word [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] assemble(input int inst);
    logic [3:0] w;
    w = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (inst == 0) w[3-i] = bits_q[i];
      else           w[i]   = bits_q[i];
    end
    return w;
  endfunction

  // Called just after the edge that sampled (v,s,d); cyc is the cycle showing results.
  task automatic model_step(input bit v, input bit s, input bit d);
    logic [3:0] w;
    if (v) begin
      if (s) begin
        if (in_prog) begin
          err_due_q[0].push_back(cyc);
          err_due_q[1].push_back(cyc);
        end
        bits_q.delete();
        bits_q.push_back(d);
        in_prog = 1'b1;
      end else if (in_prog) begin
        bits_q.push_back(d);
        if (bits_q.size() == 4) begin
          cnt_exp = cnt_exp + 8'd1;
          for (int i = 0; i < 2; i++) begin
            w = assemble(i);
            last_word[i] = w;
            exp_q[i].push_back({cnt_exp, w});
            due_q[i].push_back(cyc);
          end
          bits_q.delete();
          in_prog = 1'b0;
        end
      end
    end
    busy_exp = in_prog;
  endtask

  task automatic send(input bit v, input bit s, input bit d);
    sin_valid = v;
    sin_start = s;
    sin_data  = d;
    @(posedge clk);
    #1;
    model_step(v, s, d);
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin_data  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 1'b0);
  endtask

  // bits[3] is sent first and carries the start flag.
  task automatic send_word(input logic [3:0] bits, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send(1'b1, i == 3, bits[i]);
      if (i != 0) idle(gap);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    sin_valid = 1'b0;
    sin_start = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    bits_q.delete();
    in_prog  = 1'b0;
    busy_exp = 1'b0;
    cnt_exp  = 8'd0;
    last_word[0] = 4'd0;
    last_word[1] = 4'd0;
  endtask

  // Monitor: pops expected loads/errors whenever the DUT presents them.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (ld[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_load%0d", i), 32'd1, 32'd0);
          end else begin
            check($sformatf("load_cycle%0d", i), cyc, due_q[i].pop_front());
            check($sformatf("load_word%0d", i), {wc[i], d_o[i]}, exp_q[i].pop_front());
          end
        end else if (due_q[i].size() != 0 && due_q[i][0] <= cyc) begin
          check($sformatf("missed_load%0d", i), 32'd0, 32'd1);
          void'(due_q[i].pop_front());
          void'(exp_q[i].pop_front());
        end
        if (fe[i]) begin
          if (err_due_q[i].size() == 0) check($sformatf("unexpected_frame_err%0d", i), 32'd1, 32'd0);
          else check($sformatf("frame_err_cycle%0d", i), cyc, err_due_q[i].pop_front());
        end else if (err_due_q[i].size() != 0 && err_due_q[i][0] <= cyc) begin
          check($sformatf("missed_frame_err%0d", i), 32'd0, 32'd1);
          void'(err_due_q[i].pop_front());
        end
        check($sformatf("busy%0d", i), bz[i], busy_exp);
        check($sformatf("d_out_hold%0d", i), d_o[i], last_word[i]);
        check($sformatf("word_cnt%0d", i), wc[i], cnt_exp);
        check($sformatf("load_fe_excl%0d", i), ld[i] & fe[i], 1'b0);
      end
    end
  end

  initial begin
    last_word[0] = 4'd0;
    last_word[1] = 4'd0;
    repeat (2) @(posedge clk);
    do_reset();
    mon_en = 1'b1;
    check("reset_d_out", {d_out_m, d_out_l}, 8'd0);
    check("reset_flags", {load_m, busy_m, fe_m, load_l, busy_l, fe_l}, 6'd0);
    check("reset_word_cnt", {wc_m, wc_l}, 16'd0);

    // one bit per clock
    send_word(4'b1010, 0);
    check("t1_load", load_m, 1'b1);
    check("t1_d_out", d_out_m, 4'b1010);
    check("t1_word_cnt", wc_m, 8'd1);
    idle(2);

    // back-to-back, second start in the load cycle
    send_word(4'b1010, 0);
    send_word(4'b1100, 0);
    check("t2_d_out", d_out_m, 4'b1100);
    idle(2);

    // stray bits in IDLE, then gapped word
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send_word(4'b1101, 3);
    check("t3_d_out", d_out_m, 4'b1101);
    idle(2);

    // abort after two bits
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    send_word(4'b0011, 0);
    check("t4_d_out", d_out_m, 4'b0011);
    idle(2);

    // reset mid-word
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    do_reset();
    check("t5_reset_outs", {d_out_m, load_m, busy_m, fe_m, wc_m}, 15'd0);
    send_word(4'b0110, 0);
    check("t5_d_out", d_out_m, 4'b0110);
    idle(2);

    // LSB-first ordering and counter wrap
    send_word(4'b1000, 0);
    check("t6_lsb_d_out", d_out_l, 4'b0001);
    idle(2);
    do_reset();
    repeat (256) send_word(4'($urandom_range(0, 15)), 0);
    idle(2);
    check("t6_wrap", {wc_m, wc_l}, 16'd0);

    // randomized traffic
    do_reset();
    repeat (3000) send($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    idle(3);

    mon_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pending_loads%0d", i), exp_q[i].size(), 32'd0);
      check($sformatf("pending_errs%0d", i), err_due_q[i].size(), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
